// File: rtl/can_frame_tx_pkg.sv
// can_frame_tx_pkg: shared constants and state encoding for the CAN frame transmitter
package can_frame_tx_pkg;
  localparam int ID_BITS = 11;
  localparam int DLC_BITS = 4;
  localparam int CRC_BITS = 15;
  localparam logic [CRC_BITS-1:0] CRC15_POLY = 15'h4599;
  typedef enum logic [3:0] {
    ST_IDLE, ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC,
    ST_CRC_DEL, ST_ACK_SLOT, ST_ACK_DEL, ST_EOF, ST_IFS
  } tx_state_e;
endpackage

// File: rtl/can_crc15.sv
// can_crc15: serial CRC-15 accumulator, MSB first, one bit per enabled sp edge
module can_crc15
  import can_frame_tx_pkg::*;
(
  input  logic                sp,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  input  logic                bit_in,
  output logic [CRC_BITS-1:0] crc
);
  logic [CRC_BITS-1:0] crc_q;
  always_ff @(posedge sp) begin
    if (reset || clear) crc_q <= '0;
    else if (en) crc_q <= {crc_q[CRC_BITS-2:0], 1'b0} ^ ((bit_in ^ crc_q[CRC_BITS-1]) ? CRC15_POLY : '0);
  end
  assign crc = crc_q;
endmodule

// File: rtl/can_frame_tx.sv
// can_frame_tx: serializes one standard CAN data/remote frame with CRC-15, bit stuffing,
// arbitration-loss and ACK monitoring; isStuff flags inserted bits for loop-back capture.
module can_frame_tx
  import can_frame_tx_pkg::*;
#(
  parameter int EOF_BITS  = 7,
  parameter int IFS_BITS  = 3,
  parameter int STUFF_RUN = 5
) (
  input  logic        sp,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] id,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  input  logic        CAN_RX,
  output logic        CAN_TX,
  output logic        busy,
  output logic        isStuff,
  output logic        done,
  output logic        arb_lost,
  output logic        ack_err
);
  tx_state_e state_q, nxt_st;
  logic [5:0] cnt_q, nxt_cnt, data_last;
  logic [3:0] run_q, bytes;
  logic [10:0] id_q;
  logic rtr_q;
  logic [3:0] dlc_q;
  logic [63:0] data_q;
  logic tx_q, stuff_q, busy_q, done_q, arb_q, ack_q;
  logic nxt_bit, do_stuff, lost, crc_en;
  logic [CRC_BITS-1:0] crc;
  // state_q/cnt_q name the last frame bit driven; a stuff bit leaves them untouched
  always_comb begin
    bytes = dlc_q > 4'd8 ? 4'd8 : dlc_q;
    data_last = {3'(bytes - 4'd1), 3'b111};
    nxt_st = state_q;
    nxt_cnt = cnt_q + 6'd1;
    case (state_q)
      ST_SOF:      begin nxt_st = ST_ARB; nxt_cnt = '0; end
      ST_ARB:      if (cnt_q == 6'(ID_BITS)) begin nxt_st = ST_CTRL; nxt_cnt = '0; end
      ST_CTRL:     if (cnt_q == 6'(DLC_BITS + 1)) begin nxt_st = (rtr_q || bytes == 4'd0) ? ST_CRC : ST_DATA; nxt_cnt = '0; end
      ST_DATA:     if (cnt_q == data_last) begin nxt_st = ST_CRC; nxt_cnt = '0; end
      ST_CRC:      if (cnt_q == 6'(CRC_BITS - 1)) begin nxt_st = ST_CRC_DEL; nxt_cnt = '0; end
      ST_CRC_DEL:  begin nxt_st = ST_ACK_SLOT; nxt_cnt = '0; end
      ST_ACK_SLOT: begin nxt_st = ST_ACK_DEL; nxt_cnt = '0; end
      ST_ACK_DEL:  begin nxt_st = ST_EOF; nxt_cnt = '0; end
      ST_EOF:      if (cnt_q == 6'(EOF_BITS - 1)) begin nxt_st = ST_IFS; nxt_cnt = '0; end
      ST_IFS:      if (cnt_q == 6'(IFS_BITS - 1)) begin nxt_st = ST_IDLE; nxt_cnt = '0; end
      default:     begin nxt_st = ST_IDLE; nxt_cnt = '0; end
    endcase
    case (nxt_st)
      ST_ARB:  nxt_bit = nxt_cnt == 6'(ID_BITS) ? rtr_q : id_q[4'(ID_BITS - 1) - nxt_cnt[3:0]];
      ST_CTRL: nxt_bit = nxt_cnt > 6'd1 && dlc_q[2'(3'd5 - nxt_cnt[2:0])];
      ST_DATA: nxt_bit = data_q[~nxt_cnt];
      ST_CRC:  nxt_bit = crc[4'(CRC_BITS - 1) - nxt_cnt[3:0]];
      default: nxt_bit = 1'b1;
    endcase
    do_stuff = state_q inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC} && run_q == 4'(STUFF_RUN);
    lost = state_q == ST_ARB && !stuff_q && tx_q && !CAN_RX;
    crc_en = !do_stuff && nxt_st inside {ST_ARB, ST_CTRL, ST_DATA};
  end
  can_crc15 u_crc (
    .sp(sp), .reset(reset), .clear(state_q == ST_IDLE), .en(crc_en), .bit_in(nxt_bit), .crc(crc)
  );
  always_ff @(posedge sp) if (state_q == ST_IDLE && start) begin
    id_q <= id;
    rtr_q <= rtr;
    dlc_q <= dlc;
    data_q <= data;
  end
  always_ff @(posedge sp) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      run_q <= '0;
      tx_q <= 1'b1;
      stuff_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      arb_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      arb_q <= 1'b0;
      ack_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (start) begin
          state_q <= ST_SOF;
          cnt_q <= '0;
          run_q <= 4'd1;
          tx_q <= 1'b0;
          stuff_q <= 1'b0;
          busy_q <= 1'b1;
        end
      end else if (lost) begin
        state_q <= ST_IDLE;
        cnt_q <= '0;
        run_q <= '0;
        tx_q <= 1'b1;
        busy_q <= 1'b0;
        arb_q <= 1'b1;
      end else if (do_stuff) begin
        tx_q <= ~tx_q;
        stuff_q <= 1'b1;
        run_q <= 4'd1;
      end else begin
        state_q <= nxt_st;
        cnt_q <= nxt_cnt;
        tx_q <= nxt_bit;
        stuff_q <= 1'b0;
        run_q <= nxt_st inside {ST_ARB, ST_CTRL, ST_DATA, ST_CRC} ? (nxt_bit == tx_q ? run_q + 4'd1 : 4'd1) : '0;
        ack_q <= state_q == ST_ACK_SLOT && CAN_RX;
        done_q <= nxt_st == ST_IDLE;
        busy_q <= nxt_st != ST_IDLE;
      end
    end
  end
  assign CAN_TX = tx_q;
  assign isStuff = stuff_q;
  assign busy = busy_q;
  assign done = done_q;
  assign arb_lost = arb_q;
  assign ack_err = ack_q;
endmodule

// File: tb/tb_can_frame_tx.sv
// tb_can_frame_tx: table of frames checked bit-by-bit against a reference serializer, plus arbitration and reset sequences
module tb_can_frame_tx;
  typedef struct {
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        ack_lvl;
    logic        ign;
    int          exp_len;
    logic        chk6;
    logic [5:0]  exp_tx6;
    logic [5:0]  exp_st6;
  } frame_t;
  logic sp = 1'b0, reset = 1'b1, start = 1'b0, rtr = 1'b0;
  logic [10:0] id = '0;
  logic [3:0] dlc = '0;
  logic [63:0] data = '0;
  logic rx_ovr = 1'b0, rx_val = 1'b1;
  logic can_rx, can_tx, busy, is_stuff, done, arb_lost, ack_err;
  int errs = 0, checks = 0;
  assign can_rx = rx_ovr ? rx_val : can_tx;
  always #5 sp = ~sp;
  can_frame_tx dut (
    .sp(sp), .reset(reset), .start(start), .id(id), .rtr(rtr), .dlc(dlc), .data(data),
    .CAN_RX(can_rx), .CAN_TX(can_tx), .busy(busy), .isStuff(is_stuff), .done(done),
    .arb_lost(arb_lost), .ack_err(ack_err)
  );
  function automatic logic [5:0] obs();
    return {can_tx, is_stuff, busy, done, ack_err, arb_lost};
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // entry layout {tx, stuff, busy, done, ack_err, arb_lost}; called and returns on a negedge
  task automatic run_frame(input frame_t f);
    logic u[$];
    logic [5:0] sb[$];
    logic [5:0] e, o, tx6, st6;
    logic [14:0] crc;
    logic fb, last, prev;
    int run, slen, ackidx, nb, r, maxrun, done_at;
    crc = '0; last = 1'b0; prev = 1'b0; run = 0; r = 0; maxrun = 0; done_at = -1; tx6 = '0; st6 = '0;
    u.push_back(1'b0);
    for (int i = 10; i >= 0; i--) u.push_back(f.id[i]);
    u.push_back(f.rtr);
    u.push_back(1'b0);
    u.push_back(1'b0);
    for (int i = 3; i >= 0; i--) u.push_back(f.dlc[i]);
    nb = f.rtr ? 0 : (f.dlc > 4'd8 ? 64 : 8 * int'(f.dlc));
    for (int i = 0; i < nb; i++) u.push_back(f.data[63-i]);
    foreach (u[i]) begin
      fb = u[i] ^ crc[14];
      crc = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0);
    end
    for (int i = 14; i >= 0; i--) u.push_back(crc[i]);
    foreach (u[i]) begin
      if (run == 5) begin
        sb.push_back({~last, 1'b1, 1'b1, 3'b000});
        last = ~last;
        run = 1;
      end
      run = (run > 0 && u[i] == last) ? run + 1 : 1;
      last = u[i];
      sb.push_back({u[i], 1'b0, 1'b1, 3'b000});
    end
    if (run == 5) sb.push_back({~last, 1'b1, 1'b1, 3'b000});
    slen = sb.size();
    ackidx = slen + 1;
    repeat (13) sb.push_back(6'b101000);
    sb[ackidx+1][1] = f.ack_lvl;
    sb.push_back(6'b100100);
    id = f.id; rtr = f.rtr; dlc = f.dlc; data = f.data; start = 1'b1;
    @(negedge sp);
    start = 1'b0;
    for (int k = 0; sb.size() > 0; k++) begin
      e = sb.pop_front();
      o = obs();
      check($sformatf("id%0h bit%0d {tx,stf,busy,done,ack,arb}", f.id, k), 64'(o), 64'(e));
      if (o[2] && done_at < 0) done_at = k;
      if (k < 6) begin
        tx6[5-k] = o[5];
        st6[5-k] = o[4];
      end
      if (k < slen) begin
        r = (k > 0 && o[5] == prev) ? r + 1 : 1;
        prev = o[5];
        if (r > maxrun) maxrun = r;
      end
      rx_ovr = (k == ackidx);
      rx_val = f.ack_lvl;
      start = (k == 10) && f.ign;
      if (k == 10 && f.ign) begin
        id = ~f.id; rtr = ~f.rtr; dlc = ~f.dlc; data = ~f.data;
      end
      if (sb.size() > 0) @(negedge sp);
    end
    check($sformatf("id%0h max run<=5", f.id), 64'(maxrun <= 5), 64'(1));
    if (f.exp_len > 0) check($sformatf("id%0h done latency", f.id), 64'(done_at), 64'(f.exp_len));
    if (f.chk6) begin
      check("first6 tx", 64'(tx6), 64'(f.exp_tx6));
      check("first6 stuff", 64'(st6), 64'(f.exp_st6));
    end
  endtask
  initial begin
    frame_t tbl[6];
    int bad;
    tbl[0] = '{11'h000, 1'b0, 4'd0, 64'h0, 1'b0, 1'b0, 53, 1'b1, 6'b000001, 6'b000001};
    tbl[1] = '{11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 1'b0, 1'b1, 0, 1'b0, 6'b0, 6'b0};
    tbl[2] = '{11'h000, 1'b0, 4'd0, 64'h0, 1'b1, 1'b0, 53, 1'b0, 6'b0, 6'b0};
    tbl[3] = '{11'h2AA, 1'b1, 4'd4, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 0, 1'b0, 6'b0, 6'b0};
    tbl[4] = '{11'h7FF, 1'b0, 4'd15, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 0, 1'b0, 6'b0, 6'b0};
    tbl[5] = '{11'h555, 1'b0, 4'd8, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 0, 1'b0, 6'b0, 6'b0};
    repeat (3) @(negedge sp);
    check("reset state", 64'(obs()), 64'(6'b100000));
    reset = 1'b0;
    @(negedge sp);
    for (int i = 0; i < 6; i++) run_frame(tbl[i]);
    id = 11'h400; rtr = 1'b0; dlc = 4'd0; data = '0; start = 1'b1;
    @(negedge sp);
    start = 1'b0;
    check("arb sof", 64'(obs()), 64'(6'b001000));
    @(negedge sp);
    check("arb id10", 64'(obs()), 64'(6'b101000));
    rx_ovr = 1'b1; rx_val = 1'b0;
    @(negedge sp);
    rx_ovr = 1'b0;
    check("arb lost", 64'(obs()), 64'(6'b100001));
    bad = 0;
    repeat (60) begin
      @(negedge sp);
      if (obs() !== 6'b100000) bad++;
    end
    check("arb quiet after loss", 64'(bad), 64'(0));
    id = 11'h123; rtr = 1'b0; dlc = 4'd8; data = 64'h0123_4567_89AB_CDEF; start = 1'b1;
    @(negedge sp);
    start = 1'b0;
    repeat (25) @(negedge sp);
    check("busy before reset", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge sp);
    check("mid-frame reset", 64'(obs()), 64'(6'b100000));
    reset = 1'b0;
    @(negedge sp);
    check("idle after reset", 64'(obs()), 64'(6'b100000));
    run_frame(tbl[1]);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
